// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: tracks pending destination tags for NSTG downstream stages and
// resolves NSRC source operands against them. Optional counters under `FWD_STATS_EN`.
module fwd_bypass_unit #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSTG = 2,
  parameter int NSRC = 2,
  parameter int TW   = 2,
  localparam int SW  = $clog2(NSTG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_vld,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TW-1:0]        iss_tnew,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic [NSTG*DW-1:0]   stg_data,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC*DW-1:0]   src_raw,
  output logic [NSRC*DW-1:0]   fwd_data,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]          cnt_stall,
  output logic [31:0]          cnt_fwd
`endif
);

  logic [NSTG-1:0]         tag_vld;
  logic [NSTG-1:0][AW-1:0] tag_addr;
  logic [NSTG-1:0][TW-1:0] tag_tnew;
  logic [NSRC-1:0]         pending;

  // A stalled consumer injects a bubble; the same issue is re-presented next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_addr <= '0;
      tag_tnew <= '0;
    end else if (flush) begin
      tag_vld <= '0;
    end else if (!freeze) begin
      tag_vld[0]  <= iss_vld & ~stall;
      tag_addr[0] <= iss_addr;
      tag_tnew[0] <= iss_tnew;
      for (int k = 1; k < NSTG; k++) begin
        tag_vld[k]  <= tag_vld[k-1];
        tag_addr[k] <= tag_addr[k-1];
        tag_tnew[k] <= (tag_tnew[k-1] != '0) ? tag_tnew[k-1] - TW'(1) : '0;
      end
    end
  end

  // Scan oldest to youngest so the youngest matching producer decides the outcome,
  // including a pending one hiding an older ready copy.
  always_comb begin
    fwd_data = src_raw;
    fwd_sel  = '0;
    pending  = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (tag_vld[k] && (tag_addr[k] == src_addr[j*AW +: AW]) &&
            (src_addr[j*AW +: AW] != '0)) begin
          if (tag_tnew[k] == '0) begin
            pending[j]             = 1'b0;
            fwd_data[j*DW +: DW]   = stg_data[k*DW +: DW];
            fwd_sel[j*SW +: SW]    = SW'(k + 1);
          end else begin
            pending[j]             = 1'b1;
            fwd_data[j*DW +: DW]   = src_raw[j*DW +: DW];
            fwd_sel[j*SW +: SW]    = '0;
          end
        end
      end
    end
  end

  assign stall = |pending;

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_stall <= '0;
      cnt_fwd   <= '0;
    end else if (!freeze) begin
      if (stall)
        cnt_stall <= cnt_stall + 32'd1;
      if (|fwd_sel)
        cnt_fwd <= cnt_fwd + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed self-checking bench for fwd_bypass_unit at default parameters.
module tb_fwd_bypass_unit;

  localparam logic [31:0] RAW_A = 32'hAAAA_0000;
  localparam logic [31:0] RAW_B = 32'hBBBB_0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_vld;
  logic [4:0]  iss_addr;
  logic [1:0]  iss_tnew;
  logic        freeze;
  logic        flush;
  logic [63:0] stg_data;
  logic [9:0]  src_addr;
  logic [63:0] src_raw;
  logic [63:0] fwd_data;
  logic [3:0]  fwd_sel;
  logic        stall;
`ifdef FWD_STATS_EN
  logic [31:0] cnt_stall;
  logic [31:0] cnt_fwd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fwd_bypass_unit dut (
    .clk(clk), .rst_n(rst_n), .iss_vld(iss_vld), .iss_addr(iss_addr), .iss_tnew(iss_tnew),
    .freeze(freeze), .flush(flush), .stg_data(stg_data), .src_addr(src_addr), .src_raw(src_raw),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall)
`ifdef FWD_STATS_EN
    , .cnt_stall(cnt_stall), .cnt_fwd(cnt_fwd)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] a, input logic [1:0] t);
    iss_vld  = v;
    iss_addr = a;
    iss_tnew = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    issue(1'b0, 5'd0, 2'd0);
    freeze = 1'b0;
    flush  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freeze = 1'b0; flush = 1'b0;
    issue(1'b0, 5'd0, 2'd0);
    src_addr = {5'd3, 5'd5};
    src_raw  = {RAW_B, RAW_A};
    stg_data = 64'h0;
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (fwd_sel !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_sel: got %h expected 0", fwd_sel); end
    n_checks++; if (fwd_data !== {RAW_B, RAW_A}) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected %h", fwd_data, {RAW_B, RAW_A}); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++; if (stall !== 1'b0 || fwd_sel !== 4'h0 || fwd_data !== {RAW_B, RAW_A}) begin
      n_fail++; $display("[TB] FAIL post_reset: got stall=%b sel=%h data=%h", stall, fwd_sel, fwd_data); end
  endtask

  task automatic test_forward_timing();
    issue(1'b1, 5'd5, 2'd0);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    stg_data = {32'h5555_5555, 32'h0000_1234};
    #1;
    n_checks++; if (fwd_sel !== 4'b0001 || fwd_data[31:0] !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL fwd_stage0: got sel=%h data=%h expected sel=1 data=1234", fwd_sel, fwd_data[31:0]); end
    n_checks++; if (fwd_data[63:32] !== RAW_B || stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL fwd_stage0_ch1: got data=%h stall=%b expected %h 0", fwd_data[63:32], stall, RAW_B); end
    tick();
    stg_data = {32'h0000_1234, 32'h9999_9999};
    #1;
    n_checks++; if (fwd_sel !== 4'b0010 || fwd_data[31:0] !== 32'h1234) begin
      n_fail++; $display("[TB] FAIL fwd_stage1: got sel=%h data=%h expected sel=2 data=1234", fwd_sel, fwd_data[31:0]); end
    tick();
    n_checks++; if (fwd_sel !== 4'h0 || fwd_data[31:0] !== RAW_A) begin
      n_fail++; $display("[TB] FAIL fwd_retired: got sel=%h data=%h expected sel=0 data=%h", fwd_sel, fwd_data[31:0], RAW_A); end
  endtask

  task automatic test_load_stall();
    src_addr = {5'd3, 5'd5};
    stg_data = {32'hCAFE_0003, 32'hDEAD_0000};
    issue(1'b1, 5'd3, 2'd1);
    tick();
    issue(1'b1, 5'd7, 2'd0);
    #1;
    n_checks++; if (stall !== 1'b1 || fwd_sel[3:2] !== 2'd0 || fwd_data[63:32] !== RAW_B) begin
      n_fail++; $display("[TB] FAIL load_pending: got stall=%b sel1=%0d data1=%h expected 1 0 %h", stall, fwd_sel[3:2], fwd_data[63:32], RAW_B); end
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2 || fwd_data[63:32] !== 32'hCAFE_0003) begin
      n_fail++; $display("[TB] FAIL load_ready: got stall=%b sel1=%0d data1=%h expected 0 2 cafe0003", stall, fwd_sel[3:2], fwd_data[63:32]); end
    src_addr = {5'd3, 5'd7};
    #1;
    n_checks++; if (fwd_sel[1:0] !== 2'd0 || fwd_data[31:0] !== RAW_A) begin
      n_fail++; $display("[TB] FAIL issue_dropped_on_stall: got sel0=%0d data0=%h expected 0 %h", fwd_sel[1:0], fwd_data[31:0], RAW_A); end
    tick(); tick();
  endtask

  task automatic test_priority();
    src_addr = {5'd0, 5'd7};
    issue(1'b1, 5'd7, 2'd0);
    tick(); tick();
    issue(1'b0, 5'd0, 2'd0);
    stg_data = {32'h22, 32'h11};
    #1;
    n_checks++; if (fwd_sel[1:0] !== 2'd1 || fwd_data[31:0] !== 32'h11) begin
      n_fail++; $display("[TB] FAIL youngest_wins: got sel0=%0d data0=%h expected 1 11", fwd_sel[1:0], fwd_data[31:0]); end
    tick(); tick();
    issue(1'b1, 5'd7, 2'd0);
    tick();
    issue(1'b1, 5'd7, 2'd2);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    n_checks++; if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd0 || fwd_data[31:0] !== RAW_A) begin
      n_fail++; $display("[TB] FAIL pending_masks_ready: got stall=%b sel0=%0d data0=%h expected 1 0 %h", stall, fwd_sel[1:0], fwd_data[31:0], RAW_A); end
    tick();
    n_checks++; if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd0) begin
      n_fail++; $display("[TB] FAIL pending_stage1_tnew1: got stall=%b sel0=%0d expected 1 0", stall, fwd_sel[1:0]); end
    tick();
    n_checks++; if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
      n_fail++; $display("[TB] FAIL pending_drained: got stall=%b sel=%h expected 0 0", stall, fwd_sel); end
    src_addr = {5'd0, 5'd0};
    issue(1'b1, 5'd0, 2'd0);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    n_checks++; if (fwd_sel !== 4'h0 || fwd_data !== {RAW_B, RAW_A}) begin
      n_fail++; $display("[TB] FAIL r0_not_forwarded: got sel=%h data=%h expected 0 %h", fwd_sel, fwd_data, {RAW_B, RAW_A}); end
    tick(); tick();
  endtask

  task automatic test_freeze_flush();
    src_addr = {5'd3, 5'd5};
    stg_data = {32'h0BAD_0001, 32'h0BAD_0000};
    issue(1'b1, 5'd3, 2'd1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (stall !== 1'b1) begin
        n_fail++; $display("[TB] FAIL freeze_hold_%0d: got stall=%b expected 1", i, stall); end
    end
    freeze = 1'b0;
    tick();
    n_checks++; if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2 || fwd_data[63:32] !== 32'h0BAD_0001) begin
      n_fail++; $display("[TB] FAIL freeze_release: got stall=%b sel1=%0d data1=%h expected 0 2 0bad0001", stall, fwd_sel[3:2], fwd_data[63:32]); end
    tick();
    issue(1'b1, 5'd5, 2'd0);
    tick();
    issue(1'b1, 5'd3, 2'd1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    n_checks++; if (stall !== 1'b1 || fwd_sel !== 4'b0010) begin
      n_fail++; $display("[TB] FAIL pre_flush: got stall=%b sel=%h expected 1 2", stall, fwd_sel); end
    freeze = 1'b1; flush = 1'b1;
    tick();
    freeze = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== 4'h0 || fwd_data !== {RAW_B, RAW_A}) begin
      n_fail++; $display("[TB] FAIL flush_over_freeze: got stall=%b sel=%h data=%h expected 0 0 raw", stall, fwd_sel, fwd_data); end
  endtask

  task automatic test_async_reset();
    issue(1'b1, 5'd3, 2'd1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL async_pre: got stall=%b expected 1", stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
      n_fail++; $display("[TB] FAIL async_reset_clear: got stall=%b sel=%h expected 0 0", stall, fwd_sel); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    do_reset();
    src_addr = {5'd3, 5'd5};
    issue(1'b1, 5'd3, 2'd1);
    tick();
    issue(1'b0, 5'd0, 2'd0);
    tick(); tick();
    n_checks++; if (cnt_stall !== 32'd1 || cnt_fwd !== 32'd1) begin
      n_fail++; $display("[TB] FAIL stats_counts: got stall=%0d fwd=%0d expected 1 1", cnt_stall, cnt_fwd); end
  endtask
`endif

  initial begin
    $display("[TB] starting fwd_bypass_unit bench");
    test_reset();
    test_forward_timing();
    test_load_stall();
    test_priority();
    test_freeze_flush();
    test_async_reset();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
